pcie_read_scheduler: RTL

- Sequences block reads through the fake PCIe bridge's AXI4 read channels (AR out, R in).
- Accepts a command of base address plus number of 2 KB blocks. Issues one 32-beat INCR burst per block, with at most MAX_OUTSTANDING bursts in flight.
- Checks every returned beat: address tag in RDATA[511:448], RLAST placement, RRESP. Reports done and sticky errors to the control side.

---
 rtl/pcie_sched_pkg.sv | 16 +
 rtl/pcie_beat_checker.sv | 77 +++++++
 rtl/pcie_read_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pcie_sched_pkg.sv
// rtl/pcie_sched_pkg.sv - shared constants and state encoding for the PCIe read scheduler
package pcie_sched_pkg;

   localparam int BEAT_BYTES  = 64;
   localparam int BURST_BYTES = 2048;

   localparam logic [2:0] ARSIZE_64B   = 3'b110;
   localparam logic [1:0] ARBURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

endpackage

// File: rtl/pcie_beat_checker.sv
// rtl/pcie_beat_checker.sv - per-beat tag/RLAST/RRESP checker with burst-boundary tracking
module pcie_beat_checker
   import pcie_sched_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int BURST_BEATS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              beat_i,
   input  logic [ADDR_W-1:0] tag_i,
   input  logic              last_i,
   input  logic [1:0]        resp_i,
   output logic              burst_done_o,
   output logic              err_tag_o,
   output logic              err_last_o,
   output logic              err_resp_o
);

   localparam int IDX_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_BEATS - 1);

   logic [ADDR_W-1:0] expect_addr_q, expect_addr_d;
   logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
   logic              err_tag_q, err_tag_d;
   logic              err_last_q, err_last_d;
   logic              err_resp_q, err_resp_d;
   logic              at_last;

   assign at_last      = (beat_idx_q == LAST_IDX);
   assign burst_done_o = beat_i & at_last;

   // Burst boundaries come from the beat index alone so a misplaced RLAST cannot desync counting.
   always_comb begin
      expect_addr_d = expect_addr_q;
      beat_idx_d    = beat_idx_q;
      err_tag_d     = err_tag_q;
      err_last_d    = err_last_q;
      err_resp_d    = err_resp_q;
      if (clear_i) begin
         expect_addr_d = base_i;
         beat_idx_d    = '0;
         err_tag_d     = 1'b0;
         err_last_d    = 1'b0;
         err_resp_d    = 1'b0;
      end else if (beat_i) begin
         expect_addr_d = expect_addr_q + ADDR_W'(BEAT_BYTES);
         beat_idx_d    = at_last ? '0 : beat_idx_q + 1'b1;
         err_tag_d     = err_tag_q  | (tag_i != expect_addr_q);
         err_last_d    = err_last_q | (last_i != at_last);
         err_resp_d    = err_resp_q | (resp_i != 2'b00);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         expect_addr_q <= '0;
         beat_idx_q    <= '0;
         err_tag_q     <= 1'b0;
         err_last_q    <= 1'b0;
         err_resp_q    <= 1'b0;
      end else begin
         expect_addr_q <= expect_addr_d;
         beat_idx_q    <= beat_idx_d;
         err_tag_q     <= err_tag_d;
         err_last_q    <= err_last_d;
         err_resp_q    <= err_resp_d;
      end
   end

   assign err_tag_o  = err_tag_q;
   assign err_last_o = err_last_q;
   assign err_resp_o = err_resp_q;

endmodule

// File: rtl/pcie_read_scheduler.sv
// rtl/pcie_read_scheduler.sv - issues 2 KB AXI4 read bursts with bounded outstanding count
// Optional cycle counter built when PCIE_READ_SCHED_PERF_EN is defined.
module pcie_read_scheduler
   import pcie_sched_pkg::*;
#(
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 512,
   parameter int BURST_BEATS     = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [CNT_W-1:0]  CMD_BLOCKS,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR_TAG,
   output logic              ERR_LAST,
   output logic              ERR_RESP,
   output logic [31:0]       CYCLE_COUNT,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic [7:0]        M_AXI_ARLEN,
   output logic [2:0]        M_AXI_ARSIZE,
   output logic [1:0]        M_AXI_ARBURST,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [DATA_W-1:0] M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RLAST,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
   logic [CNT_W-1:0]  issue_left_q, issue_left_d;
   logic [CNT_W-1:0]  recv_left_q, recv_left_d;
   logic [3:0]        outstanding_q, outstanding_d;
   logic              arvalid_q, arvalid_d;

   logic cmd_hs, ar_hs, r_hs, burst_done;
   logic unused_rdata;

   assign cmd_hs       = CMD_VALID & (state_q == ST_IDLE);
   assign ar_hs        = arvalid_q & M_AXI_ARREADY;
   assign r_hs         = M_AXI_RVALID & (state_q == ST_RUN);
   assign unused_rdata = ^M_AXI_RDATA[DATA_W-ADDR_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (CMD_VALID) state_d = (CMD_BLOCKS == '0) ? ST_FINISH : ST_RUN;
         ST_RUN:    if (recv_left_q == '0) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      CMD_READY    = (state_q == ST_IDLE);
      BUSY         = (state_q == ST_RUN);
      DONE         = (state_q == ST_FINISH);
      M_AXI_RREADY = (state_q == ST_RUN);
   end

   // ARVALID is registered from next-state counts so ARADDR/ARVALID never glitch mid-handshake.
   always_comb begin
      issue_addr_d  = issue_addr_q;
      issue_left_d  = issue_left_q;
      recv_left_d   = recv_left_q;
      outstanding_d = outstanding_q;
      arvalid_d     = 1'b0;
      if (cmd_hs) begin
         issue_addr_d  = CMD_ADDR;
         issue_left_d  = CMD_BLOCKS;
         recv_left_d   = CMD_BLOCKS;
         outstanding_d = '0;
         arvalid_d     = (CMD_BLOCKS != '0);
      end else if (state_q == ST_RUN) begin
         if (ar_hs) begin
            issue_addr_d = issue_addr_q + ADDR_W'(BURST_BEATS * BEAT_BYTES);
            issue_left_d = issue_left_q - 1'b1;
         end
         if (burst_done) recv_left_d = recv_left_q - 1'b1;
         case ({ar_hs, burst_done})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
         endcase
         arvalid_d = (issue_left_d != '0) && (outstanding_d < 4'(MAX_OUTSTANDING));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_addr_q  <= '0;
         issue_left_q  <= '0;
         recv_left_q   <= '0;
         outstanding_q <= '0;
         arvalid_q     <= 1'b0;
      end else begin
         issue_addr_q  <= issue_addr_d;
         issue_left_q  <= issue_left_d;
         recv_left_q   <= recv_left_d;
         outstanding_q <= outstanding_d;
         arvalid_q     <= arvalid_d;
      end
   end

   assign M_AXI_ARADDR  = issue_addr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARLEN   = 8'(BURST_BEATS - 1);
   assign M_AXI_ARSIZE  = ARSIZE_64B;
   assign M_AXI_ARBURST = ARBURST_INCR;

   pcie_beat_checker #(
      .ADDR_W      (ADDR_W),
      .BURST_BEATS (BURST_BEATS)
   ) u_checker (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (cmd_hs),
      .base_i       (CMD_ADDR),
      .beat_i       (r_hs),
      .tag_i        (M_AXI_RDATA[DATA_W-1 -: ADDR_W]),
      .last_i       (M_AXI_RLAST),
      .resp_i       (M_AXI_RRESP),
      .burst_done_o (burst_done),
      .err_tag_o    (ERR_TAG),
      .err_last_o   (ERR_LAST),
      .err_resp_o   (ERR_RESP)
   );

`ifdef PCIE_READ_SCHED_PERF_EN
   logic [31:0] perf_cnt_q;
   logic [31:0] cycle_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_cnt_q    <= '0;
         cycle_count_q <= '0;
      end else begin
         if (cmd_hs)
            perf_cnt_q <= '0;
         else if ((state_q == ST_RUN) && (perf_cnt_q != 32'hFFFF_FFFF))
            perf_cnt_q <= perf_cnt_q + 1'b1;
         if (state_q == ST_FINISH)
            cycle_count_q <= perf_cnt_q;
      end
   end

   assign CYCLE_COUNT = cycle_count_q;
`else
   assign CYCLE_COUNT = 32'd0;
`endif

endmodule
